sar_logic_cf_param: RTL and testbench
=====================================

// Module: sar_logic_cf_param
// PURPOSE
//  Parametrised coarse/fine SAR controller: N-bit successive approximation with the first K decisions
//  from the coarse comparator/DAC, then a DAC handoff (DS) to the fine array for the remaining N-K bits.
//  Sits between the comparators/bootstrap switch and the cap-array bottom-plate drivers; one sample per cnvst.
// PARAMETERS
//  N         10  resolution in bits (N >= 2)
//  K         4   coarse decisions, 1 <= K < N (elaboration error otherwise)
//  T_SAMPLE  1   cycles s_clk held high after cnvst acceptance (>= 1)
// PORTS
//  clk                  in   1    single clock
//  rst                  in   1    synchronous, active-high reset
//  cnvst                in   1    start request; sampled only in S_WAIT
//  cmp_out              in   1    fine comparator result (1 = input >= DAC)
//  cmp_out_coarse       in   1    coarse comparator result
//  sar                  out  N    result/trial code; final and held from eoc until the next acceptance
//  eoc                  out  1    one-cycle end-of-conversion pulse
//  busy                 out  1    high from acceptance until eoc cycle, inclusive
//  s_clk                out  1    bootstrap switch clock, combinational: 1 in S_WAIT and S_SAMPLE
//  cmp_clk              out  1    fine comparator clock (registered)
//  cmp_clk_coarse       out  1    coarse comparator clock (registered)
//  fine_btm             out  2N   fine array switches; [2N-1:N] P half, [N-1:0] N half
//  coarse_btm           out  2K   coarse array switches; [2K-1:K] P half, [K-1:0] N half
//  fine_switch_drain    out  1    fine array drain switch, active-low release
//  coarse_switch_drain  out  1    coarse array drain switch
// BEHAVIOUR
//  Reset: sar=0, eoc=0, busy=0, cmp_clk=0, cmp_clk_coarse=0, fine_btm=0, coarse_btm=0, both drains=1,
//   state=S_WAIT (s_clk=1). rst mid-conversion aborts; all of the above take effect at the next edge.
//  All outputs except s_clk are registered. i = decision index 0..N-1; b = N-1-i.
//  S_WAIT: cnvst=1 -> S_SAMPLE; sar<=1<<(N-1), fine_btm<=0, coarse_btm<=0, drains<=1, busy<=1.
//   cnvst while busy is ignored (no queuing).
//  S_SAMPLE: T_SAMPLE cycles -> S_DRAIN.  S_DRAIN: 1 cycle, coarse_switch_drain<=0 -> S_CSET.
//  S_CSET: coarse_btm[2K-1:K]<=all 1, [K-1:0]<=0 -> S_CMP_C.
//  S_CMP_C: cmp_clk_coarse<=1 -> S_DEC_C (cmp_clk_coarse is 1 exactly during S_DEC_C).
//  S_DEC_C (i<K): cmp_out_coarse=1 -> coarse_btm[K-1-i]<=1; else -> sar[b]<=0, coarse_btm[2K-1-i]<=0.
//   Always sar[b-1]<=1. i<K-1 -> S_CMP_C; else -> S_DS1.
//  S_DS1: fine_switch_drain<=0.  S_DS2: for j<K, if sar[N-1-j]: fine_btm[2N-1-j]<=1, fine_btm[N-1-j]<=1;
//   fine_btm[2N-1-K:N]<=all 1 -> S_CMP_F.
//  S_CMP_F: cmp_clk<=1 -> S_DEC_F (cmp_clk is 1 exactly during S_DEC_F).
//  S_DEC_F (i>=K): cmp_out=1 -> fine_btm[b]<=1; else -> sar[b]<=0, fine_btm[b+N]<=0.
//   b>0: sar[b-1]<=1, -> S_CMP_F.  b==0: eoc<=1, -> S_WAIT; busy drops one cycle later.
//  Latency: acceptance edge to the first edge where eoc=1 is T_SAMPLE+4+2N edges (25 for defaults),
//   independent of K. Back-to-back: cnvst held high restarts on the cycle after eoc.
//  Bit pointer never underflows; sar[b-1] is never written when b==0.
// CONFIGURATION
//  SAR_LOGIC_INV_OUT_EN defined: adds outputs s_clk_not, fine_btm_not[2N], coarse_btm_not[2K],
//   fine_switch_drain_not, coarse_switch_drain_not = bitwise complements, combinational, zero skew
//   in cycles. Undefined: those ports do not exist; behaviour otherwise identical.
// STRUCTURE
//  sar_logic_pkg: state enum localparams (S_WAIT..S_DEC_F), phase encoding (coarse/fine), clog2 helper.
//  Sub-module sar_dac_switch_ctrl: owns fine_btm/coarse_btm/drain registers;
//   inputs: state, b, decision, sar snapshot. Top keeps FSM, bit pointer, sar, eoc, busy.
// TESTING  (bench comparator: cmp = (VIN_CODE >= trial sar), same model drives both comparators)
//  VIN_CODE=10'h2A5, defaults, pulse cnvst -> eoc exactly 25 cycles later, sar=10'h2A5, busy 1->0 after eoc.
//  VIN_CODE=10'h3FF -> sar=10'h3FF, coarse_btm=8'hFF; VIN_CODE=0 -> sar=0, coarse_btm=8'h00, fine_btm[9:0]=0.
//  Assert rst at cycle 12 of a conversion -> next edge all outputs at reset values; no eoc; new cnvst converts correctly.
//  cnvst held high continuously for 3 conversions -> 3 eoc pulses spaced 26 cycles; mid-busy cnvst edges ignored.
//  Sweep N=6,K=1 and N=12,K=11,T_SAMPLE=3 over all/random codes -> sar==VIN_CODE, latency=T_SAMPLE+4+2N.
//  With SAR_LOGIC_INV_OUT_EN: each _not output equals the complement of its partner on every cycle.

Source files
------------

// File: rtl/sar_logic_pkg.sv
// sar_logic_pkg: shared types and helpers for the coarse/fine SAR controller.
// FSM state encoding, coarse/fine phase encoding and a ceil(log2) helper
// used to size the bit pointer and the sample counter.
`timescale 1ns/1ps
package sar_logic_pkg;

  typedef enum logic [3:0] {
    S_WAIT   = 4'd0,
    S_SAMPLE = 4'd1,
    S_DRAIN  = 4'd2,
    S_CSET   = 4'd3,
    S_CMP_C  = 4'd4,
    S_DEC_C  = 4'd5,
    S_DS1    = 4'd6,
    S_DS2    = 4'd7,
    S_CMP_F  = 4'd8,
    S_DEC_F  = 4'd9
  } state_t;

  typedef enum logic {
    PH_COARSE = 1'b0,
    PH_FINE   = 1'b1
  } phase_t;

  // Ceiling log2, minimum 1 so that a one-value range still gets a bit.
  function automatic int sar_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Which comparator/array is in charge in a given state.
  function automatic phase_t phase_of(input state_t s);
    return (s inside {S_DS1, S_DS2, S_CMP_F, S_DEC_F}) ? PH_FINE : PH_COARSE;
  endfunction

endpackage

// File: rtl/sar_logic_cf_param_dac.sv
// sar_dac_switch_ctrl: bottom-plate switch and drain registers for the
// coarse and fine capacitor arrays. The top supplies the FSM state, the
// current bit pointer, the active comparator decision and the coarse
// decision bits of the SAR register (needed for the DAC handoff).
`timescale 1ns/1ps
module sar_dac_switch_ctrl
  import sar_logic_pkg::*;
#(
  parameter int N     = 10,
  parameter int K     = 4,
  parameter int BIT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  state_t           i_state,
  input  logic [BIT_W-1:0] i_bit,
  input  logic             i_dec,
  input  logic [K-1:0]     i_sar_msb,
  output logic [2*N-1:0]   o_fine_btm,
  output logic [2*K-1:0]   o_coarse_btm,
  output logic             o_fine_drain,
  output logic             o_coarse_drain
);

  logic [2*N-1:0] r_fine_btm;
  logic [2*K-1:0] r_coarse_btm;
  logic           r_fine_drain;
  logic           r_coarse_drain;

  // Per-state switch updates; a new acceptance clears arrays and closes drains.
  // NOTE: non-blocking (<=) for all state so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      r_fine_btm     <= '0;
      r_coarse_btm   <= '0;
      r_fine_drain   <= 1'b1;
      r_coarse_drain <= 1'b1;
    end else begin
      case (i_state)
        S_DRAIN: r_coarse_drain <= 1'b0;
        S_CSET:  r_coarse_btm   <= {{K{1'b1}}, {K{1'b0}}};
        S_DEC_C: begin
          // Decision index i = N-1-b selects one P and one N switch.
          for (int j = 0; j < K; j++) begin
            if (N - 1 - int'(i_bit) == j) begin
              if (i_dec) r_coarse_btm[K-1-j]   <= 1'b1;
              else       r_coarse_btm[2*K-1-j] <= 1'b0;
            end
          end
        end
        S_DS1: r_fine_drain <= 1'b0;
        S_DS2: begin
          // Copy the coarse result onto the fine array, remaining P bits high.
          for (int j = 0; j < K; j++) begin
            if (i_sar_msb[K-1-j]) begin
              r_fine_btm[2*N-1-j] <= 1'b1;
              r_fine_btm[N-1-j]   <= 1'b1;
            end
          end
          r_fine_btm[2*N-1-K:N] <= '1;
        end
        S_DEC_F: begin
          for (int j = 0; j < N - K; j++) begin
            if (int'(i_bit) == j) begin
              if (i_dec) r_fine_btm[j]   <= 1'b1;
              else       r_fine_btm[j+N] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fine_btm     = r_fine_btm;
  assign o_coarse_btm   = r_coarse_btm;
  assign o_fine_drain   = r_fine_drain;
  assign o_coarse_drain = r_coarse_drain;

endmodule

// File: rtl/sar_logic_cf_param.sv
// sar_logic_cf_param: parametrised coarse/fine SAR controller. The first K
// decisions come from the coarse comparator, then the DAC is handed over to
// the fine array for the remaining N-K bits. One conversion per accepted cnvst.
// Optional feature macro: SAR_LOGIC_INV_OUT_EN adds complemented switch outputs.
`timescale 1ns/1ps
module sar_logic_cf_param
  import sar_logic_pkg::*;
#(
  parameter int N        = 10,
  parameter int K        = 4,
  parameter int T_SAMPLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cnvst,
  input  logic           cmp_out,
  input  logic           cmp_out_coarse,
  output logic [N-1:0]   sar,
  output logic           eoc,
  output logic           busy,
  output logic           s_clk,
  output logic           cmp_clk,
  output logic           cmp_clk_coarse,
  output logic [2*N-1:0] fine_btm,
  output logic [2*K-1:0] coarse_btm,
  output logic           fine_switch_drain,
`ifdef SAR_LOGIC_INV_OUT_EN
  output logic           s_clk_not,
  output logic [2*N-1:0] fine_btm_not,
  output logic [2*K-1:0] coarse_btm_not,
  output logic           fine_switch_drain_not,
  output logic           coarse_switch_drain_not,
`endif
  output logic           coarse_switch_drain
);

  localparam int BIT_W = sar_clog2(N);
  localparam int CNT_W = sar_clog2(T_SAMPLE + 1);

  if (N < 2) begin : g_bad_n
    $error("sar_logic_cf_param: N must be >= 2");
  end
  if (K < 1 || K >= N) begin : g_bad_k
    $error("sar_logic_cf_param: K must satisfy 1 <= K < N");
  end
  if (T_SAMPLE < 1) begin : g_bad_t
    $error("sar_logic_cf_param: T_SAMPLE must be >= 1");
  end

  state_t           r_state;
  logic [N-1:0]     r_sar;
  logic [BIT_W-1:0] r_bit;
  logic [CNT_W-1:0] r_cnt;
  logic             r_eoc;
  logic             r_busy;
  logic             r_cmp_clk;
  logic             r_cmp_clk_coarse;

  logic   w_start;
  logic   w_dec;
  phase_t w_phase;

  assign w_start = (r_state == S_WAIT) && cnvst;
  assign w_phase = phase_of(r_state);
  assign w_dec   = (w_phase == PH_FINE) ? cmp_out : cmp_out_coarse;

  // Conversion FSM: sequencing, bit pointer, SAR register and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_WAIT;
      r_sar            <= '0;
      r_bit            <= '0;
      r_cnt            <= '0;
      r_eoc            <= 1'b0;
      r_busy           <= 1'b0;
      r_cmp_clk        <= 1'b0;
      r_cmp_clk_coarse <= 1'b0;
    end else begin
      r_eoc            <= 1'b0;
      r_cmp_clk        <= 1'b0;
      r_cmp_clk_coarse <= 1'b0;
      case (r_state)
        S_WAIT: begin
          r_busy <= cnvst;
          if (cnvst) begin
            r_sar   <= {1'b1, {(N-1){1'b0}}};
            r_bit   <= BIT_W'(N - 1);
            r_cnt   <= '0;
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (int'(r_cnt) == T_SAMPLE - 1) r_state <= S_DRAIN;
          else                             r_cnt   <= r_cnt + 1'b1;
        end
        S_DRAIN: r_state <= S_CSET;
        S_CSET:  r_state <= S_CMP_C;
        S_CMP_C: begin
          r_cmp_clk_coarse <= 1'b1;
          r_state          <= S_DEC_C;
        end
        S_DS1:   r_state <= S_DS2;
        S_DS2:   r_state <= S_CMP_F;
        S_CMP_F: begin
          r_cmp_clk <= 1'b1;
          r_state   <= S_DEC_F;
        end
        S_DEC_C, S_DEC_F: begin
          // Resolve bit b and set the next trial bit; b-1 never matches when b==0.
          for (int j = 0; j < N; j++) begin
            if (j == int'(r_bit) && !w_dec) r_sar[j] <= 1'b0;
            if (j == int'(r_bit) - 1)       r_sar[j] <= 1'b1;
          end
          if (r_state == S_DEC_C) begin
            r_bit   <= r_bit - 1'b1;
            r_state <= (int'(r_bit) == N - K) ? S_DS1 : S_CMP_C;
          end else if (r_bit == '0) begin
            r_eoc   <= 1'b1;
            r_state <= S_WAIT;
          end else begin
            r_bit   <= r_bit - 1'b1;
            r_state <= S_CMP_F;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  sar_dac_switch_ctrl #(
    .N     (N),
    .K     (K),
    .BIT_W (BIT_W)
  ) u_dac (
    .clk            (clk),
    .rst            (rst),
    .i_start        (w_start),
    .i_state        (r_state),
    .i_bit          (r_bit),
    .i_dec          (w_dec),
    .i_sar_msb      (r_sar[N-1:N-K]),
    .o_fine_btm     (fine_btm),
    .o_coarse_btm   (coarse_btm),
    .o_fine_drain   (fine_switch_drain),
    .o_coarse_drain (coarse_switch_drain)
  );

  assign sar            = r_sar;
  assign eoc            = r_eoc;
  assign busy           = r_busy;
  assign cmp_clk        = r_cmp_clk;
  assign cmp_clk_coarse = r_cmp_clk_coarse;
  assign s_clk          = (r_state == S_WAIT) || (r_state == S_SAMPLE);

`ifdef SAR_LOGIC_INV_OUT_EN
  assign s_clk_not               = ~s_clk;
  assign fine_btm_not            = ~fine_btm;
  assign coarse_btm_not          = ~coarse_btm;
  assign fine_switch_drain_not   = ~fine_switch_drain;
  assign coarse_switch_drain_not = ~coarse_switch_drain;
`endif

endmodule

// File: tb/tb_sar_logic_cf_param.sv
// tb_sar_logic_cf_param: self-checking bench for sar_logic_cf_param.
// Three instances: defaults (N=10,K=4,T=1), N=6,K=1 and N=12,K=11,T=3.
// Each comparator is modelled as cmp = (vin >= trial sar) for both arrays.
`timescale 1ns/1ps
module tb_sar_logic_cf_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Instance A: defaults
  logic       cnvst_a, cmp_a;
  logic [9:0] vin_a, sar_a;
  logic       eoc_a, busy_a, s_clk_a, cclk_a, cclkc_a, fdr_a, cdr_a;
  logic [19:0] fine_a;
  logic [7:0]  coarse_a;
  assign cmp_a = (vin_a >= sar_a);

  // Instance B: N=6, K=1
  logic       cnvst_b, cmp_b;
  logic [5:0] vin_b, sar_b;
  logic       eoc_b, busy_b, s_clk_b, cclk_b, cclkc_b, fdr_b, cdr_b;
  logic [11:0] fine_b;
  logic [1:0]  coarse_b;
  assign cmp_b = (vin_b >= sar_b);

  // Instance C: N=12, K=11, T_SAMPLE=3
  logic        cnvst_c, cmp_c;
  logic [11:0] vin_c, sar_c;
  logic        eoc_c, busy_c, s_clk_c, cclk_c, cclkc_c, fdr_c, cdr_c;
  logic [23:0] fine_c;
  logic [21:0] coarse_c;
  assign cmp_c = (vin_c >= sar_c);

`ifdef SAR_LOGIC_INV_OUT_EN
  logic s_clk_n_a, fdr_n_a, cdr_n_a; logic [19:0] fine_n_a; logic [7:0]  coarse_n_a;
  logic s_clk_n_b, fdr_n_b, cdr_n_b; logic [11:0] fine_n_b; logic [1:0]  coarse_n_b;
  logic s_clk_n_c, fdr_n_c, cdr_n_c; logic [23:0] fine_n_c; logic [21:0] coarse_n_c;
`endif

  sar_logic_cf_param u_dut_a (
    .clk(clk), .rst(rst), .cnvst(cnvst_a), .cmp_out(cmp_a), .cmp_out_coarse(cmp_a),
    .sar(sar_a), .eoc(eoc_a), .busy(busy_a), .s_clk(s_clk_a), .cmp_clk(cclk_a),
    .cmp_clk_coarse(cclkc_a), .fine_btm(fine_a), .coarse_btm(coarse_a),
    .fine_switch_drain(fdr_a),
`ifdef SAR_LOGIC_INV_OUT_EN
    .s_clk_not(s_clk_n_a), .fine_btm_not(fine_n_a), .coarse_btm_not(coarse_n_a),
    .fine_switch_drain_not(fdr_n_a), .coarse_switch_drain_not(cdr_n_a),
`endif
    .coarse_switch_drain(cdr_a)
  );

  sar_logic_cf_param #(.N(6), .K(1), .T_SAMPLE(1)) u_dut_b (
    .clk(clk), .rst(rst), .cnvst(cnvst_b), .cmp_out(cmp_b), .cmp_out_coarse(cmp_b),
    .sar(sar_b), .eoc(eoc_b), .busy(busy_b), .s_clk(s_clk_b), .cmp_clk(cclk_b),
    .cmp_clk_coarse(cclkc_b), .fine_btm(fine_b), .coarse_btm(coarse_b),
    .fine_switch_drain(fdr_b),
`ifdef SAR_LOGIC_INV_OUT_EN
    .s_clk_not(s_clk_n_b), .fine_btm_not(fine_n_b), .coarse_btm_not(coarse_n_b),
    .fine_switch_drain_not(fdr_n_b), .coarse_switch_drain_not(cdr_n_b),
`endif
    .coarse_switch_drain(cdr_b)
  );

  sar_logic_cf_param #(.N(12), .K(11), .T_SAMPLE(3)) u_dut_c (
    .clk(clk), .rst(rst), .cnvst(cnvst_c), .cmp_out(cmp_c), .cmp_out_coarse(cmp_c),
    .sar(sar_c), .eoc(eoc_c), .busy(busy_c), .s_clk(s_clk_c), .cmp_clk(cclk_c),
    .cmp_clk_coarse(cclkc_c), .fine_btm(fine_c), .coarse_btm(coarse_c),
    .fine_switch_drain(fdr_c),
`ifdef SAR_LOGIC_INV_OUT_EN
    .s_clk_not(s_clk_n_c), .fine_btm_not(fine_n_c), .coarse_btm_not(coarse_n_c),
    .fine_switch_drain_not(fdr_n_c), .coarse_switch_drain_not(cdr_n_c),
`endif
    .coarse_switch_drain(cdr_c)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic eoc_of(input int w);
    case (w)
      0:       return eoc_a;
      1:       return eoc_b;
      default: return eoc_c;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [11:0] sar_of(input int w);
    case (w)
      0:       return {2'b00, sar_a};
      1:       return {6'b000000, sar_b};
      default: return sar_c;
    endcase
  endfunction

  // One pulsed conversion on instance w; lat = edges from acceptance to eoc, -1 on timeout.
  task automatic run_conv(input int w, input int code, output int lat, output logic [11:0] res);
    lat = -1;
    case (w)
      0:       begin vin_a = code[9:0];  cnvst_a = 1'b1; end
      1:       begin vin_b = code[5:0];  cnvst_b = 1'b1; end
      default: begin vin_c = code[11:0]; cnvst_c = 1'b1; end
    endcase
    @(negedge clk);
    cnvst_a = 1'b0; cnvst_b = 1'b0; cnvst_c = 1'b0;
    check($sformatf("busy_after_accept[w%0d]", w), 64'(busy_of(w)), 64'd1);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (eoc_of(w)) begin
        lat = c;
        break;
      end
    end
    res = sar_of(w);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_sar"},    64'(sar_a),    64'd0);
    check({tag, "_eoc"},    64'(eoc_a),    64'd0);
    check({tag, "_busy"},   64'(busy_a),   64'd0);
    check({tag, "_cmpclk"}, 64'({cclk_a, cclkc_a}), 64'd0);
    check({tag, "_fine"},   64'(fine_a),   64'd0);
    check({tag, "_coarse"}, 64'(coarse_a), 64'd0);
    check({tag, "_drains"}, 64'({fdr_a, cdr_a}), 64'd3);
    check({tag, "_s_clk"},  64'(s_clk_a),  64'd1);
  endtask

`ifdef SAR_LOGIC_INV_OUT_EN
  logic [30:0] inv_exp_a;
  always @(negedge clk) begin
    inv_exp_a = ~{s_clk_a, fine_a, coarse_a, fdr_a, cdr_a};
    check("inv_outputs_a", 64'({s_clk_n_a, fine_n_a, coarse_n_a, fdr_n_a, cdr_n_a}), 64'(inv_exp_a));
  end
`endif

  typedef struct {
    int which;
    int code;
    int exp_sar;
    int exp_lat;
    bit chk_btm;
    int exp_coarse;
    int exp_fine;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [11:0] res;
    int          eoc_at[3];
    int          n_eoc;
    bit          busy_gap;
    bit          seen;

    // Directed vectors: expected switch patterns hand-derived (final P and N halves equal the code).
    vecs.push_back('{0, 'h2A5, 'h2A5, 25, 1'b1, 'hAA, 'hA96A5});
    vecs.push_back('{0, 'h3FF, 'h3FF, 25, 1'b1, 'hFF, 'hFFFFF});
    vecs.push_back('{0, 'h000, 'h000, 25, 1'b1, 'h00, 'h00000});
    vecs.push_back('{0, 'h155, 'h155, 25, 1'b1, 'h55, 'h55555});
    vecs.push_back('{0, 'h200, 'h200, 25, 1'b1, 'h88, 'h80200});
    vecs.push_back('{1, 'h3F,  'h3F,  17, 1'b0, 0, 0});
    vecs.push_back('{1, 'h00,  'h00,  17, 1'b0, 0, 0});
    vecs.push_back('{1, 'h20,  'h20,  17, 1'b0, 0, 0});
    vecs.push_back('{2, 'hFFF, 'hFFF, 31, 1'b0, 0, 0});
    vecs.push_back('{2, 'h000, 'h000, 31, 1'b0, 0, 0});
    vecs.push_back('{2, 'h800, 'h800, 31, 1'b0, 0, 0});

    rst = 1'b1;
    cnvst_a = 1'b0; cnvst_b = 1'b0; cnvst_c = 1'b0;
    vin_a = '0; vin_b = '0; vin_c = '0;
    repeat (3) @(negedge clk);
    check_reset_a("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy_b", 64'(busy_b), 64'd0);
    check("idle_busy_c", 64'(busy_c), 64'd0);

    foreach (vecs[v]) begin
      run_conv(vecs[v].which, vecs[v].code, lat, res);
      check($sformatf("latency[%0d]", v), 64'(lat), 64'(vecs[v].exp_lat));
      check($sformatf("sar[%0d]", v), 64'(res), 64'(vecs[v].exp_sar));
      check($sformatf("busy_at_eoc[%0d]", v), 64'(busy_of(vecs[v].which)), 64'd1);
      if (vecs[v].chk_btm) begin
        check($sformatf("coarse_btm[%0d]", v), 64'(coarse_a), 64'(vecs[v].exp_coarse));
        check($sformatf("fine_btm[%0d]", v), 64'(fine_a), 64'(vecs[v].exp_fine));
        check($sformatf("drains[%0d]", v), 64'({fdr_a, cdr_a}), 64'd0);
      end
      @(negedge clk);
      check($sformatf("eoc_one_cycle[%0d]", v), 64'(eoc_of(vecs[v].which)), 64'd0);
      check($sformatf("busy_drop[%0d]", v), 64'(busy_of(vecs[v].which)), 64'd0);
      check($sformatf("sar_held[%0d]", v), 64'(sar_of(vecs[v].which)), 64'(vecs[v].exp_sar));
    end

    // N=6, K=1: every code.
    for (int code = 0; code < 64; code++) begin
      run_conv(1, code, lat, res);
      check($sformatf("n6_lat[%0d]", code), 64'(lat), 64'd17);
      check($sformatf("n6_sar[%0d]", code), 64'(res), 64'(code));
      @(negedge clk);
    end

    // N=12, K=11, T_SAMPLE=3: random codes.
    for (int r = 0; r < 20; r++) begin
      int code;
      code = int'($urandom_range(0, 4095));
      run_conv(2, code, lat, res);
      check($sformatf("n12_lat[%0d]", code), 64'(lat), 64'd31);
      check($sformatf("n12_sar[%0d]", code), 64'(res), 64'(code));
      @(negedge clk);
    end

    // cnvst pulses while busy are ignored.
    vin_a = 10'h0F0;
    cnvst_a = 1'b1;
    @(negedge clk);
    cnvst_a = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      cnvst_a = (c == 5 || c == 12);
      if (eoc_a) begin
        lat = c;
        break;
      end
    end
    cnvst_a = 1'b0;
    check("midbusy_lat", 64'(lat), 64'd25);
    check("midbusy_sar", 64'(sar_a), 64'h0F0);
    @(negedge clk);
    check("midbusy_no_restart", 64'(busy_a), 64'd0);

    // cnvst held high: three back-to-back conversions 26 cycles apart.
    vin_a = 10'h1C3;
    cnvst_a = 1'b1;
    @(negedge clk);
    n_eoc = 0;
    busy_gap = 1'b0;
    eoc_at = '{-1, -1, -1};
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (!busy_a) busy_gap = 1'b1;
      if (eoc_a) begin
        check($sformatf("b2b_sar[%0d]", n_eoc), 64'(sar_a), 64'h1C3);
        eoc_at[n_eoc] = c;
        n_eoc++;
        if (n_eoc == 3) begin
          cnvst_a = 1'b0;
          break;
        end
      end
    end
    cnvst_a = 1'b0;
    check("b2b_count", 64'(n_eoc), 64'd3);
    check("b2b_eoc0", 64'(eoc_at[0]), 64'd25);
    check("b2b_eoc1", 64'(eoc_at[1]), 64'd51);
    check("b2b_eoc2", 64'(eoc_at[2]), 64'd77);
    check("b2b_busy_continuous", 64'(busy_gap), 64'd0);
    @(negedge clk);
    check("b2b_busy_drop", 64'(busy_a), 64'd0);

    // Reset at cycle 12 of a conversion aborts it.
    vin_a = 10'h2A5;
    cnvst_a = 1'b1;
    @(negedge clk);
    cnvst_a = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_abort_busy", 64'(busy_a), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_a("abort");
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (eoc_a || busy_a) seen = 1'b1;
    end
    check("abort_no_eoc", 64'(seen), 64'd0);
    run_conv(0, 'h2A5, lat, res);
    check("after_abort_lat", 64'(lat), 64'd25);
    check("after_abort_sar", 64'(res), 64'h2A5);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
